// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture block: FSM encoding and the
// saturation value of the measurement counters.
package pwm_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

    // Largest count representable in an R_SIZE+1 bit measurement field.
    function automatic int unsigned cnt_max(input int unsigned r_size);
        return (32'd1 << (r_size + 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// Signal bundle between the PWM capture block and its user: the line and
// clear going in, the duty/period report and status coming out.
interface pwm_capture_if #(
    parameter int R_SIZE = 8
);
    logic              pwm_in;
    logic              clear;
    logic [R_SIZE:0]   duty;
    logic [R_SIZE:0]   period;
    logic              valid;
    logic              stuck;
    logic              busy;

    modport master (
        output pwm_in, clear,
        input  duty, period, valid, stuck, busy
    );

    modport slave (
        input  pwm_in, clear,
        output duty, period, valid, stuck, busy
    );
endinterface

// File: rtl/pwm_capture_sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous line followed by a history
// flop that yields single-cycle rise and fall strobes.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2   // must be at least 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q[0] <= 1'b0;
        end else begin
            sync_q[0] <= d_i;
        end
    end

    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_stage
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q[gi] <= 1'b0;
            end else begin
                sync_q[gi] <= sync_q[gi-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  =  sync_q[SYNC_STAGES-1] & ~hist_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] &  hist_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rising-to-rising period of a PWM line in clk
// cycles, reporting each completed period or a stuck-line timeout.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int R_SIZE      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    pwm_capture_if.slave   bus
);
    localparam int            CW  = R_SIZE + 1;
    localparam logic [CW-1:0] MAX = CW'(cnt_max(R_SIZE));
    localparam logic [CW-1:0] ONE = CW'(1);

    logic line_lvl, line_rise, line_fall;

    state_e        state_q, state_d;
    logic [CW-1:0] hi_cnt_q, hi_cnt_d;
    logic [CW-1:0] per_cnt_q, per_cnt_d;
    logic [CW-1:0] duty_q, duty_d;
    logic [CW-1:0] period_q, period_d;
    logic          stuck_q, stuck_d;
    logic          valid_q, valid_d;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (bus.pwm_in),
        .level_o (line_lvl),
        .rise_o  (line_rise),
        .fall_o  (line_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            hi_cnt_q  <= '0;
            per_cnt_q <= '0;
            duty_q    <= '0;
            period_q  <= '0;
            stuck_q   <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_cnt_q  <= hi_cnt_d;
            per_cnt_q <= per_cnt_d;
            duty_q    <= duty_d;
            period_q  <= period_d;
            stuck_q   <= stuck_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hi_cnt_d  = hi_cnt_q;
        per_cnt_d = per_cnt_q;
        duty_d    = duty_q;
        period_d  = period_q;
        stuck_d   = stuck_q;
        valid_d   = 1'b0;

        if (bus.clear) begin
            state_d   = ST_IDLE;
            hi_cnt_d  = '0;
            per_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (line_rise) begin
                        hi_cnt_d  = ONE;
                        per_cnt_d = ONE;
                        state_d   = ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (line_fall) begin
                        // Saturate so a fall at the limit times out next cycle.
                        per_cnt_d = (per_cnt_q == MAX) ? per_cnt_q : per_cnt_q + ONE;
                        state_d   = ST_LOW;
                    end else if (per_cnt_q == MAX) begin
                        duty_d    = line_lvl ? MAX : '0;
                        period_d  = '0;
                        stuck_d   = 1'b1;
                        valid_d   = 1'b1;
                        hi_cnt_d  = '0;
                        per_cnt_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        hi_cnt_d  = hi_cnt_q + ONE;
                        per_cnt_d = per_cnt_q + ONE;
                    end
                end
                ST_LOW: begin
                    if (line_rise) begin
                        duty_d    = hi_cnt_q;
                        period_d  = per_cnt_q;
                        stuck_d   = 1'b0;
                        valid_d   = 1'b1;
                        hi_cnt_d  = ONE;
                        per_cnt_d = ONE;
                        state_d   = ST_HIGH;
                    end else if (per_cnt_q == MAX) begin
                        duty_d    = line_lvl ? MAX : '0;
                        period_d  = '0;
                        stuck_d   = 1'b1;
                        valid_d   = 1'b1;
                        hi_cnt_d  = '0;
                        per_cnt_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        per_cnt_d = per_cnt_q + ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.duty   = duty_q;
    assign bus.period = period_q;
    assign bus.valid  = valid_q;
    assign bus.stuck  = stuck_q;
    assign bus.busy   = (state_q != ST_IDLE);

endmodule
